// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the square-root reconstruction block.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Accumulator width wide enough that q*q + remainder never wraps internally.
  function automatic int acc_width(input int qw, input int rw);
    int a;
    a = 2 * qw;
    if (rw > a) a = rw;
    return a + 1;
  endfunction

  // Bit-counter width for a given root width.
  function automatic int cnt_width(input int qw);
    return $clog2(qw) + 1;
  endfunction

  localparam int Q_PORT_WIDTH_DEF = 8;
  localparam int CNT_W            = cnt_width(Q_PORT_WIDTH_DEF);

endpackage

// File: rtl/sqrt_restore.sv
// Rebuilds radical = q*q + remainder with a radix-2 shift-add loop,
// one multiplier bit per enabled cycle, valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for an operand pair
// BUSY  | shift-add loop running, one multiplier bit per enabled edge
// DONE  | result presented, waiting for out_ready
module sqrt_restore
  import sqrt_pkg::*;
#(
  parameter int q_port_width = 8,
  parameter int r_port_width = 9,
  parameter int width        = 16
) (
  input  logic                    clk,
  input  logic                    aclr,
  input  logic                    ena,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [q_port_width-1:0] q,
  input  logic [r_port_width-1:0] remainder,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [width-1:0]        radical,
  output logic                    overflow,
  output logic                    inconsistent
);

  localparam int AW = acc_width(q_port_width, r_port_width);
  localparam int CW = cnt_width(q_port_width);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_accept;
  logic                    w_finish;

  logic [AW-1:0]           r_acc;
  logic [AW-1:0]           r_mcand;
  logic [q_port_width-1:0] r_mplier;
  logic [CW-1:0]           r_cnt;
  logic                    r_incons_cap;

  logic [width-1:0]        r_radical;
  logic                    r_overflow;
  logic                    r_inconsistent;

  logic [AW-1:0]           w_addend;
  logic [AW-1:0]           w_acc_sum;
  logic [width-1:0]        w_radical_nxt;
  logic                    w_overflow_nxt;
  logic                    w_incons_nxt;

  // State register; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (aclr) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == CW'(q_port_width - 1)) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current bit is set.
  always_comb begin
    w_addend      = r_mplier[0] ? r_mcand : '0;
    w_acc_sum     = r_acc + w_addend;
    w_radical_nxt = width'(w_acc_sum);
    w_incons_nxt  = AW'(remainder) > (AW'(q) << 1);
  end

  // Anything above the output width means the true result did not fit.
  if (AW > width) begin : g_ovf
    assign w_overflow_nxt = |w_acc_sum[AW-1:width];
  end else begin : g_no_ovf
    assign w_overflow_nxt = 1'b0;
  end

  // Datapath: load on accept, iterate in BUSY, latch outputs on the final step
  // so the presented result is stable for the whole DONE state.
  always_ff @(posedge clk) begin
    if (aclr) begin
      r_acc          <= '0;
      r_mcand        <= '0;
      r_mplier       <= '0;
      r_cnt          <= '0;
      r_incons_cap   <= 1'b0;
      r_radical      <= '0;
      r_overflow     <= 1'b0;
      r_inconsistent <= 1'b0;
    end else if (ena) begin
      if (w_accept) begin
        r_acc        <= AW'(remainder);
        r_mcand      <= AW'(q);
        r_mplier     <= q;
        r_cnt        <= '0;
        r_incons_cap <= w_incons_nxt;
      end else if (r_state == BUSY) begin
        r_acc    <= w_acc_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (w_finish) begin
          r_radical      <= w_radical_nxt;
          r_overflow     <= w_overflow_nxt;
          r_inconsistent <= r_incons_cap;
        end
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign radical      = r_radical;
  assign overflow     = r_overflow;
  assign inconsistent = r_inconsistent;

endmodule

// File: tb/tb_sqrt_restore.sv
// Bench for sqrt_restore: directed corner cases plus random operand pairs,
// each result compared against plain integer arithmetic.
module tb_sqrt_restore;

  logic        clk;
  logic        aclr;
  logic        ena;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [8:0]  remainder;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] radical;
  logic        overflow;
  logic        inconsistent;

  int checks = 0;
  int errors = 0;

  sqrt_restore #(
    .q_port_width(8),
    .r_port_width(9),
    .width       (16)
  ) dut (
    .clk         (clk),
    .aclr        (aclr),
    .ena         (ena),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .q           (q),
    .remainder   (remainder),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .radical     (radical),
    .overflow    (overflow),
    .inconsistent(inconsistent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair, optionally freeze ena mid-flight and hold off out_ready,
  // then check the result against q*q + remainder.
  task automatic run_op(input int qv, input int rv, input int gap_at, input int gap_len,
                        input int hold, input string tag);
    int     n;
    int     e;
    logic [15:0] exp_rad;
    logic   exp_ovf;
    logic   exp_inc;
    e       = qv * qv + rv;
    exp_rad = e[15:0];
    exp_ovf = (e > 65535);
    exp_inc = (rv > 2 * qv);

    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);

    q         = qv[7:0];
    remainder = rv[8:0];
    in_valid  = 1'b1;
    tick();
    // keep in_valid high with different operands: must be ignored while busy
    q         = 8'($urandom);
    remainder = 9'($urandom);
    chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);

    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      if (gap_len > 0 && n == gap_at) ena = 1'b0;
      if (gap_len > 0 && n == gap_at + gap_len) ena = 1'b1;
      tick();
      n++;
    end
    ena = 1'b1;
    chk({tag, "_latency"}, 32'(n), 32'(8 + gap_len));
    chk({tag, "_radical"}, 32'(radical), 32'(exp_rad));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_inconsistent"}, 32'(inconsistent), 32'(exp_inc));

    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_radical"}, 32'(radical), 32'(exp_rad));
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_release_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    aclr      = 1'b1;
    ena       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q         = '0;
    remainder = '0;
    tick();
    tick();
    aclr = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_radical", 32'(radical), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_inconsistent", 32'(inconsistent), 32'd0);

    run_op(12, 5, 0, 0, 0, "basic");
    run_op(255, 510, 0, 0, 0, "max_legal");
    run_op(255, 511, 0, 0, 0, "invalid_pair");
    run_op(0, 0, 0, 0, 0, "zero");
    run_op(0, 300, 0, 0, 0, "q_zero");
    run_op(3, 2, 0, 0, 5, "backpressure");
    run_op(100, 7, 3, 3, 0, "ena_gap");

    // abort mid-BUSY: the result must be lost and reset values restored
    q         = 8'd200;
    remainder = 9'd100;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_radical", 32'(radical), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    chk("abort_never_valid", 32'(seen), 32'd0);

    for (int k = 0; k < 20; k++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 511)), 0, 0,
             int'($urandom_range(0, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_restore.md
Name: sqrt_restore

Overview:
- Inverse of the team's square-root block: takes a root `q` and a `remainder` and rebuilds `radical = q*q + remainder`.
- Iterative radix-2 shift-add: one multiplier bit per enabled cycle, with valid/ready handshakes on both sides.
- Sits after Sqrt in the match datapath as a self-check/reconstruction stage.
- Also flags overflow, and flags (q, remainder) pairs that no square root could have produced.

Parameters:
- q_port_width, 8, width of the root input `q`.
- r_port_width, 9, width of the remainder input (q_port_width+1 covers every legal remainder).
- width, 16, width of the reconstructed radical output.

Ports:
- clk  in  1  single clock, rising edge.
- aclr  in  1  reset; synchronous, active-high (despite the name); has priority over everything.
- ena  in  1  clock enable; when low all state holds, except that reset still acts.
- in_valid  in  1  q/remainder valid.
- in_ready  out  1  block can accept an operand pair.
- q  in  q_port_width  square root operand.
- remainder  in  r_port_width  remainder operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- radical  out  width  q*q+remainder, truncated to width bits.
- overflow  out  1  true result needs more than width bits.
- inconsistent  out  1  remainder > 2*q, so the pair is not a valid sqrt output.

Behaviour:
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, radical=0, overflow=0, inconsistent=0.
  - Internal accumulator, multiplicand, multiplier shift register and bit counter all 0.
- Internal accumulator width: AW = max(2*q_port_width, r_port_width)+1 bits, so no internal wrap.
- States (all transitions only on edges where ena=1 or aclr=1):
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready:
      - Capture acc=remainder (zero-extended), mcand=q, mplier=q, cnt=0.
      - Capture inconsistent = (remainder > 2*q), compared at AW bits.
      - Go to BUSY.
  - BUSY:
    - in_ready=0.
    - Each edge: if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
    - When cnt reaches q_port_width-1 on that edge, go to DONE.
  - DONE:
    - out_valid=1. radical = acc[width-1:0]. overflow = |acc[AW-1:width] (0 if AW<=width).
    - On out_ready, go to IDLE.
    - No new input is accepted in DONE.
- Latency: out_valid rises exactly q_port_width enabled edges after the accepting edge. Throughput is one result per q_port_width+2 enabled cycles.
- Backpressure: in DONE with out_ready=0, radical, overflow and inconsistent hold stable indefinitely.
- q=0: the loop still runs q_port_width cycles and the result equals remainder.
- ena=0 mid-BUSY: progress freezes and latency extends by the number of disabled cycles. Outputs keep their values.
- aclr mid-BUSY or mid-DONE: the operation is discarded and the reset values hold on the next cycle. A pending output is lost, not delivered.
- in_valid asserted while not IDLE: ignored. The upstream must hold the pair until in_ready.
- Output registers update only on the BUSY->DONE edge, so radical is stable through the whole DONE state.

Decomposition:
- Shared package sqrt_pkg holds:
  - State enum (IDLE, BUSY, DONE).
  - Function acc_width(qw, rw) returning max(2*qw, rw)+1.
  - Constant for the counter width, $clog2(q_port_width)+1.
- No sub-module: the datapath is one accumulator plus shifters, kept in a single module.

Test Plan:
- Basic: q=12, remainder=5, width=16 -> out_valid after 8 cycles; radical=149, overflow=0, inconsistent=0.
- Max legal: q=255, remainder=510 -> radical=65535, overflow=0, inconsistent=0.
- Invalid pair: q=255, remainder=511 -> true result 65536; radical=0, overflow=1, inconsistent=1.
- Zero operands: q=0, remainder=0 -> radical=0 after 8 cycles.
- Backpressure: result for q=3, r=2 (radical=11) with out_ready low 5 cycles -> radical held at 11, in_ready=0, a new in_valid is ignored. Raising out_ready returns to IDLE next edge.
- Control:
  - ena low for 3 cycles mid-BUSY -> out_valid delayed to 11 cycles after acceptance.
  - aclr at BUSY cycle 4 -> next cycle in_ready=1, out_valid=0, radical=0, and the aborted result never appears.
